bus_rr_arbiter: RTL

Parametrised shared bus with round-robin arbitration among `NUM_M` masters and one-hot address decode to `NUM_S` slave windows. It replaces the single-master bus: multiple masters request, one owner is granted at a time, and the owner's transfer is routed to the decoded slave. Read data returns to the owner with one-cycle registered latency. The block adds out-of-range error reporting, which the single-master bus lacks.

---
 rtl/bus_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 84 ++++++++
 rtl/bus_rr_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the multi-master round-robin bus.
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_M    = 2;
  localparam int DEF_NUM_S    = 4;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_OFFSET_W = 8;
  localparam int DEF_DATA_W   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin bus ownership: IDLE/GRANT FSM, rotating pointer, registered one-hot grant.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_M = DEF_NUM_M,
  localparam int OW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NUM_M-1:0] m_req,
  output logic [NUM_M-1:0] m_grant,
  output logic [OW-1:0]    owner,
  output logic             busy
);

  arb_state_e    state, nxt_state;
  logic [OW-1:0] ptr, nxt_ptr, nxt_owner;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
    return (int'(v) == NUM_M - 1) ? '0 : v + OW'(1);
  endfunction

  // First requester at or after start, wrapping modulo NUM_M.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                           input logic [OW-1:0]    start);
    logic [OW-1:0] pick;
    logic          found;
    int            k;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      k = (int'(start) + i) % NUM_M;
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = OW'(k);
      end
    end
    return pick;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_ptr   = ptr;
    case (state)
      IDLE: begin
        if (|m_req) begin
          nxt_state = GRANT;
          nxt_owner = rr_pick(m_req, ptr);
          nxt_ptr   = wrap_inc(nxt_owner);
        end
      end
      GRANT: begin
        // No preemption: only a dropped owner request lets the grant move.
        if (!m_req[owner]) begin
          if (|m_req) begin
            nxt_owner = rr_pick(m_req, wrap_inc(owner));
            nxt_ptr   = wrap_inc(nxt_owner);
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      m_grant <= '0;
    end else begin
      state   <= nxt_state;
      owner   <= nxt_owner;
      ptr     <= nxt_ptr;
      m_grant <= (nxt_state == GRANT) ? (NUM_M'(1) << nxt_owner) : '0;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared bus: round-robin owner selection, one-hot slave decode, registered read return and range error.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_M    = DEF_NUM_M,
  parameter int NUM_S    = DEF_NUM_S,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M-1:0]        m_wr,
  input  logic [NUM_M*ADDR_W-1:0] m_address,
  input  logic [NUM_M*DATA_W-1:0] m_dout,
  output logic [NUM_M-1:0]        m_grant,
  output logic [DATA_W-1:0]       m_din,
  output logic                    m_err,
  output logic [NUM_S-1:0]        s_sel,
  output logic                    s_wr,
  output logic [OFFSET_W-1:0]     s_address,
  output logic [DATA_W-1:0]       s_din,
  input  logic [NUM_S*DATA_W-1:0] s_dout
);

  localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int IW = ADDR_W - OFFSET_W;

  logic [OW-1:0]     owner;
  logic              busy;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_dout;
  logic              own_wr;
  logic [IW-1:0]     idx;
  logic              in_range;
  logic [DATA_W-1:0] sel_dout;

  rr_arbiter #(.NUM_M(NUM_M)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (m_req),
    .m_grant (m_grant),
    .owner   (owner),
    .busy    (busy)
  );

  always_comb begin
    own_addr = '0;
    own_dout = '0;
    own_wr   = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (OW'(i) == owner) begin
        own_addr = m_address[i*ADDR_W +: ADDR_W];
        own_dout = m_dout[i*DATA_W +: DATA_W];
        own_wr   = m_wr[i];
      end
    end
  end

  assign idx      = own_addr[ADDR_W-1:OFFSET_W];
  assign in_range = (32'(idx) < 32'(NUM_S));

  always_comb begin
    sel_dout = '0;
    s_sel    = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (IW'(j) == idx) begin
        sel_dout = s_dout[j*DATA_W +: DATA_W];
        s_sel[j] = busy && in_range;
      end
    end
  end

  // Out-of-range accesses never reach a slave.
  assign s_wr      = busy && in_range && own_wr;
  assign s_address = busy ? own_addr[OFFSET_W-1:0] : '0;
  assign s_din     = busy ? own_dout : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_din <= '0;
      m_err <= 1'b0;
    end else begin
      m_err <= busy && !in_range;
      if (busy && !own_wr)
        m_din <= in_range ? sel_dout : '0;
    end
  end

endmodule
